// File: rtl/onewire_seq.sv
// onewire_seq: 1-wire bit-slot sequencer (reset/write/read) driving owr_p/owr_e.
// Ports: clk, rst (sync, active-high); cmd_vld/cmd_rdy/cmd_typ/cmd_dat/cmd_pwr command in;
// rsp_vld/rsp_dat response out; owr_p/owr_e line drive pair; owr_i line input (async).
module onewire_seq #(
  parameter int CDR    = 24,
  parameter int T_RSTL = 480,
  parameter int T_RSTP = 550,
  parameter int T_RST  = 960,
  parameter int T_W0L  = 60,
  parameter int T_W1L  = 6,
  parameter int T_RDS  = 15,
  parameter int T_SLT  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_typ,
  input  logic       cmd_dat,
  input  logic       cmd_pwr,
  output logic       rsp_vld,
  output logic       rsp_dat,
  output logic       owr_p,
  output logic       owr_e,
  input  logic       owr_i
);
  localparam int PW = $clog2(CDR);
  localparam logic [PW-1:0] PMAX = PW'(CDR - 1);
  localparam logic [9:0] U_RSTL = 10'(T_RSTL);
  localparam logic [9:0] U_RSTP = 10'(T_RSTP);
  localparam logic [9:0] U_RST  = 10'(T_RST);
  localparam logic [9:0] U_W0L  = 10'(T_W0L);
  localparam logic [9:0] U_W1L  = 10'(T_W1L);
  localparam logic [9:0] U_RDS  = 10'(T_RDS);
  localparam logic [9:0] U_SLT  = 10'(T_SLT);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [9:0] us, low_len, slot_len, smp_pt;
  logic [1:0] typ, sync;
  logic dat, pwr, smp, acc, tick;
  assign acc = cmd_vld & cmd_rdy;
  assign tick = presc == PMAX;
  assign low_len = typ == 2'b00 ? U_RSTL : (typ == 2'b01 && !dat) ? U_W0L : U_W1L;
  assign slot_len = typ == 2'b00 ? U_RST : U_SLT;
  assign smp_pt = typ == 2'b00 ? U_RSTP : U_RDS;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_rdy <= 1'b1;
      rsp_vld <= 1'b0;
      rsp_dat <= 1'b0;
      owr_e <= 1'b0;
      owr_p <= 1'b0;
      presc <= '0;
      us <= '0;
      sync <= 2'b11;
      typ <= 2'b00;
      dat <= 1'b0;
      pwr <= 1'b0;
      smp <= 1'b0;
    end else begin
      sync <= {sync[0], owr_i};
      presc <= tick ? '0 : presc + 1'b1;
      us <= us + {9'd0, tick};
      rsp_vld <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (acc) begin
            presc <= '0;
            us <= '0;
            typ <= cmd_typ;
            dat <= cmd_dat;
            pwr <= cmd_pwr;
            smp <= cmd_dat;
            owr_p <= 1'b0;
            if (cmd_typ == 2'b11) begin
              state <= DONE;
              rsp_vld <= 1'b1;
              rsp_dat <= 1'b0;
            end else begin
              state <= LOW;
              cmd_rdy <= 1'b0;
            end
          end
        end
        LOW: begin
          owr_e <= us != low_len;
          if (us == low_len) state <= HIGH;
        end
        HIGH: begin
          // Single-shot sample on the first edge of the sample microsecond.
          if (typ != 2'b01 && us == smp_pt && presc == '0) smp <= typ == 2'b00 ? ~sync[1] : sync[1];
          if (us == slot_len) begin
            state <= DONE;
            rsp_vld <= 1'b1;
            rsp_dat <= smp;
            cmd_rdy <= 1'b1;
            owr_p <= typ == 2'b01 && pwr;
          end
        end
      endcase
    end
  end
endmodule
